// File: rtl/segment_scan_ctrl.sv
// Multiplexed scan controller for a common-anode multi-digit 7-segment display.
// Optional leading-zero blanking is enabled by defining SEGMENT_SCAN_LZB_EN.
module segment_scan_ctrl #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000,
  parameter int unsigned DEAD   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   i_val,
  input  logic                  i_load,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_an,
  output logic                  o_ack,
  output logic                  o_frame
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DigW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned ValW = 4 * DIGITS;

  localparam logic [CntW-1:0]   CntLast = CntW'(DIV - 1);
  localparam logic [CntW-1:0]   CntDead = CntW'(DEAD);
  localparam logic [DigW-1:0]   DigLast = DigW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AnOne   = DIGITS'(1);

  typedef enum logic {StBlank, StDrive} phase_e;

  // Hex glyphs, active-low, bit 0 = segment a .. bit 6 = segment g.
  function automatic logic [6:0] segment_ram_hex(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DigW-1:0]   dig_q, dig_d;
  logic [ValW-1:0]   shd_q, shd_d;
  logic [ValW-1:0]   disp_q, disp_d;
  logic              pend_q, pend_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              ack_q, ack_d;
  logic              frame_q, frame_d;

  logic              boundary;
  logic [ValW-1:0]   upper;
  phase_e            phase;

  always_comb begin
    boundary = (cnt_q == '0) && (dig_q == '0);

    cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    dig_d = dig_q;
    if (cnt_q == CntLast) begin
      dig_d = (dig_q == DigLast) ? '0 : dig_q + DigW'(1);
    end

    shd_d  = shd_q;
    pend_d = pend_q;
    disp_d = disp_q;
    if (boundary && pend_q) begin
      disp_d = shd_q;
      pend_d = 1'b0;
    end
    // A load in the boundary cycle stays pending for the following frame.
    if (i_load) begin
      shd_d  = i_val;
      pend_d = 1'b1;
    end

    // Outputs are built from the post-boundary value so a new frame never shows stale digits.
    upper = disp_d >> {dig_q, 2'b00};
    phase = (cnt_q < CntDead) ? StBlank : StDrive;
`ifdef SEGMENT_SCAN_LZB_EN
    if ((dig_q != '0) && (upper == '0)) begin
      phase = StBlank;
    end
`endif

    seg_d = 7'h7F;
    an_d  = '1;
    if (phase == StDrive) begin
      seg_d = segment_ram_hex(upper[3:0]);
      an_d  = ~(AnOne << dig_q);
    end

    ack_d   = boundary && pend_q;
    frame_d = boundary;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      shd_q   <= '0;
      disp_q  <= '0;
      pend_q  <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      ack_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      shd_q   <= shd_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      ack_q   <= ack_d;
      frame_q <= frame_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_an    = an_q;
  assign o_ack   = ack_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Bench for segment_scan_ctrl: directed scenarios plus random loads/resets against a
// time-indexed reference model. Honours SEGMENT_SCAN_LZB_EN when defined.
module tb_segment_scan_ctrl;

  localparam int Digits = 4;
  localparam int Div    = 8;
  localparam int Dead   = 2;
  localparam int Frame  = Digits * Div;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] val;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        ack;
  logic        frame;

  always #5 clk = ~clk;

  segment_scan_ctrl #(
    .DIGITS (Digits),
    .DIV    (Div),
    .DEAD   (Dead)
  ) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_val   (val),
    .i_load  (load),
    .o_seg   (seg),
    .o_an    (an),
    .o_ack   (ack),
    .o_frame (frame)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: cycle index since reset release, plus shadow/display/pending value.
  int          s;
  logic [15:0] m_shd;
  logic [15:0] m_disp;
  logic        m_pend;

  int         acks;
  int         blanks;
  logic [3:0] driven;
  logic [6:0] seen [4];

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got=%h exp=%h", tag, s, got, exp);
    end
  endtask

  task automatic clear_track();
    acks   = 0;
    blanks = 0;
    driven = 4'b0000;
    for (int k = 0; k < 4; k++) seen[k] = 7'h7F;
  endtask

  // Drive one cycle; outputs seen after the edge reflect the state of this cycle.
  task automatic step(input logic ld, input logic [15:0] v);
    logic        e_frame;
    logic        e_ack;
    logic [15:0] dv;
    logic [15:0] hi;
    logic        lz;
    int          pos;
    int          d;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    load = ld;
    val  = v;
    e_frame = ((s % Frame) == 0);
    e_ack   = e_frame && m_pend;
    dv      = e_ack ? m_shd : m_disp;
    pos     = s % Div;
    d       = (s / Div) % Digits;
    hi      = dv >> (4 * d);
    lz      = 1'b0;
`ifdef SEGMENT_SCAN_LZB_EN
    lz = (d > 0) && (hi == 16'h0000);
`endif
    if (pos < Dead || lz) begin
      e_seg = 7'h7F;
      e_an  = 4'hF;
    end else begin
      e_seg = glyph_tab[hi[3:0]];
      e_an  = ~(4'b0001 << d);
    end
    if (e_ack) begin
      m_disp = m_shd;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_shd  = v;
      m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
    s++;
    check_eq("seg", seg, e_seg);
    check_eq("an", an, e_an);
    check_eq("ack", ack, e_ack);
    check_eq("frame", frame, e_frame);
    if (ack) acks++;
    if (an == 4'hF) blanks++;
    else begin
      for (int k = 0; k < 4; k++) begin
        if (!an[k]) begin
          driven[k] = 1'b1;
          seen[k]   = seg;
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst  = 1'b1;
    load = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check_eq("rst_seg", seg, 7'h7F);
      check_eq("rst_an", an, 4'hF);
      check_eq("rst_ack", ack, 1'b0);
      check_eq("rst_frame", frame, 1'b0);
    end
    rst    = 1'b0;
    s      = 0;
    m_shd  = '0;
    m_disp = '0;
    m_pend = 1'b0;
    check_eq("c0_seg", seg, 7'h7F);
    check_eq("c0_an", an, 4'hF);
    check_eq("c0_ack", ack, 1'b0);
    check_eq("c0_frame", frame, 1'b0);
  endtask

  task automatic run_n(input int n);
    repeat (n) step(1'b0, 16'h0000);
  endtask

  task automatic run_to(input int p);
    while ((s % Frame) != p) step(1'b0, 16'h0000);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    val  = '0;
    s    = 0;
    clear_track();

    // Reset and first frame after release
    do_reset(3);
    step(1'b0, 16'h0000);
    check_eq("frame_c1", frame, 1'b1);
    check_eq("ack_c1", ack, 1'b0);
    run_n(2);
    check_eq("an_c3", an, 4'b1110);
    check_eq("seg_c3", seg, 7'b1000000);

    // Single load mid-frame
    run_to(10);
    clear_track();
    step(1'b1, 16'h1234);
    run_to(0);
    blanks = 0;
    run_n(Frame);
    check_eq("single_acks", acks, 1);
    check_eq("single_d0", seen[0], 7'b0011001);
    check_eq("single_d3", seen[3], 7'b1111001);
    check_eq("single_blanks", blanks, 4 * Dead);

    // Two loads within one frame: only the last is shown, one ack
    run_to(1);
    clear_track();
    step(1'b1, 16'hAAAA);
    run_n(5);
    step(1'b1, 16'hBEEF);
    run_to(0);
    run_n(Frame);
    check_eq("double_acks", acks, 1);
    check_eq("double_d0", seen[0], 7'b0001110);
    check_eq("double_d1", seen[1], 7'b0000110);
    check_eq("double_d2", seen[2], 7'b0000110);
    check_eq("double_d3", seen[3], 7'b0000011);

    // Load in the frame-boundary cycle with nothing pending
    run_to(0);
    clear_track();
    step(1'b1, 16'h00C0);
    run_n(Frame - 1);
    check_eq("coin_no_ack", acks, 0);
    step(1'b0, 16'h0000);
    check_eq("coin_ack", ack, 1'b1);
    run_n(Frame);
    check_eq("coin_d1", seen[1], 7'b1000110);

    // Reset with a value pending discards it
    run_to(5);
    step(1'b1, 16'h5555);
    run_n(3);
    do_reset(2);
    clear_track();
    run_n(2 * Frame);
    check_eq("mrst_acks", acks, 0);
    check_eq("mrst_d0", seen[0], 7'b1000000);
`ifdef SEGMENT_SCAN_LZB_EN
    check_eq("mrst_driven", driven, 4'b0001);
`else
    check_eq("mrst_driven", driven, 4'b1111);
    check_eq("mrst_d3", seen[3], 7'b1000000);
`endif

    // Leading zeros
    run_to(3);
    step(1'b1, 16'h0050);
    run_to(0);
    run_n(1);
    clear_track();
    run_n(Frame);
    check_eq("lz_d1", seen[1], 7'b0010010);
    check_eq("lz_d0", seen[0], 7'b1000000);
`ifdef SEGMENT_SCAN_LZB_EN
    check_eq("lz_driven", driven, 4'b0011);
`else
    check_eq("lz_driven", driven, 4'b1111);
`endif
    step(1'b1, 16'h0000);
    run_to(0);
    run_n(1);
    clear_track();
    run_n(Frame);
`ifdef SEGMENT_SCAN_LZB_EN
    check_eq("zero_driven", driven, 4'b0001);
`else
    check_eq("zero_driven", driven, 4'b1111);
`endif

    // Random loads and occasional resets against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 10) step(1'b1, 16'($urandom));
      else if (r == 199) do_reset($urandom_range(1, 3));
      else step(1'b0, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/segment_scan_ctrl.md
# segment_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. Holds a packed hexadecimal value, cycles through the digits with a fixed dwell time, and inserts a blanking gap between digits to suppress ghosting. Each selected nibble is converted by the team's hex glyph table `segment_ram_hex`. New values are accepted through a load strobe and applied atomically at a frame boundary, so a frame never shows a mix of old and new digits.

## Interface
- `DIGITS`, 4 — number of digits; legal range 1..8.
- `DIV`, 50000 — clock cycles per digit slot; minimum 2.
- `DEAD`, 16 — blank cycles at the start of each slot; must be less than `DIV`.

- `i_clk` in 1 — clock.
- `i_rst` in 1 — reset, synchronous, active-high.
- `i_val` in 4*DIGITS — packed value; nibble k drives digit k, with digit 0 the least significant.
- `i_load` in 1 — one-cycle strobe that captures `i_val`.
- `o_seg` out 7 — segments, active-low, bit order 0..6 = a..g.
- `o_an` out DIGITS — anode enables, active-low, one-hot-low while driving.
- `o_ack` out 1 — one-cycle pulse when a captured value becomes the displayed value.
- `o_frame` out 1 — one-cycle pulse at the start of every digit-0 slot.

## Operation
- Registers:
  - slot counter `cnt`, 0..DIV-1;
  - digit index `dig`, 0..DIGITS-1;
  - shadow register `shd`;
  - display register `disp`;
  - flag `pend`.
- Slot sequencing:
  - `cnt` increments every cycle and wraps to 0 from DIV-1.
  - On that wrap, `dig` increments and wraps from DIGITS-1 to 0.
- Per-slot state machine:
  - BLANK while cnt < DEAD: `o_an` all ones, `o_seg` = 7'b1111111.
  - DRIVE while cnt >= DEAD: anode `dig` low; `o_seg` = glyph(`disp` nibble `dig`).
- Load:
  - `i_load` high sets `shd` <= `i_val` and sets `pend`.
  - Repeated loads before application overwrite `shd`. Only the last value is shown, and `o_ack` pulses once.
- Frame boundary (the cycle with cnt==0 and dig==0):
  - `o_frame` pulses.
  - If `pend` is set: `disp` <= `shd`, `pend` cleared, `o_ack` pulses.
- Load coinciding with a frame boundary:
  - The boundary applies the previous `shd` (and acks it only if it was pending).
  - The new value is captured, stays pending, and is applied at the next frame.

## Timing
- Reset state: `cnt`=0, `dig`=0, `shd`=0, `disp`=0, `pend`=0.
- Outputs during and immediately after reset: `o_seg`=7'h7F, `o_an`=all ones, `o_ack`=0, `o_frame`=0.
- Latency:
  - `o_seg`, `o_an`, `o_ack` and `o_frame` are registered, one cycle after the counter state that produces them.
  - Cycle 0 is defined as the first cycle with `i_rst` low.
  - `o_frame` is first high in cycle 1. The first reset-release frame does not pulse `o_ack`.
  - Digit 0 is first driven in cycle DEAD+1.
- Load to display:
  - A load takes effect in the DRIVE phase of the first complete frame after capture.
  - Worst case is DIGITS*DIV+DEAD+1 cycles.
- Frame period is DIGITS*DIV cycles; `o_ack` and `o_frame` are aligned in the same cycle.
- Reset asserted mid-frame:
  - The next cycle returns to the reset state.
  - A pending value is discarded and no `o_ack` is issued.

## Configuration
- `SEGMENT_SCAN_LZB_EN` (leading-zero blanking).
- Defined: digit k (k ≥ 1) is held in BLANK for its whole slot when `disp` nibbles k..DIGITS-1 are all zero. Digit 0 is always driven, so value 0 shows a single "0". Slot timing is unchanged.
- Undefined: every digit is driven, and zeros display as "0".

## Test plan
All scenarios use DIGITS=4, DIV=8, DEAD=2.
- **Reset:** hold `i_rst` for 3 cycles.
  - Required: `o_seg`=7'h7F and `o_an`=4'hF throughout.
  - After release: `o_frame` in cycle 1, `o_an`=4'b1110 in cycle 3, `o_seg`=7'b1000000 in cycle 3.
- **Single load:** `i_load` with 16'h1234 mid-frame.
  - One `o_ack` at the next frame start.
  - Digit 0 `o_seg`=7'b0011001; digit 3 `o_seg`=7'b1111001.
  - Every slot has 2 blank cycles.
- **Double load:** 16'hAAAA then 16'hBEEF within one frame.
  - Exactly one `o_ack`; digits show F, E, E, B.
  - Digit 0 `o_seg`=7'b0001110.
- **Coincident load:** `i_load` with 16'h00C0 in the frame-boundary cycle, with nothing pending.
  - No `o_ack` this frame.
  - `o_ack` one frame (32 cycles) later; digit 1 then shows 7'b1000110.
- **Mid-frame reset:** load 16'h5555, then assert reset before the boundary.
  - No `o_ack`.
  - After release the display shows 0 on all digits, or only digit 0 with `SEGMENT_SCAN_LZB_EN`.
- **Leading-zero blanking (`SEGMENT_SCAN_LZB_EN` defined):** load 16'h0050.
  - Digits 3 and 2 are never driven.
  - Digit 1 = 7'b0010010, digit 0 = 7'b1000000.
  - With 16'h0000, only digit 0 is driven.
